// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Bundle of fetch, data-memory and datapath-control signals
//               between the instruction sequencer and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if;
  // Instruction fetch port
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [7:0]  pc;
  // Data memory handshake
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  // Datapath status inputs
  logic        zero;
  logic [7:0]  a_bus;
  // Datapath control word
  logic [2:0]  DA;
  logic [2:0]  AA;
  logic [2:0]  BA;
  logic [5:0]  IM;
  logic        CS;
  logic        MB;
  logic [2:0]  FS;
  logic        MD;
  logic        RW;
  // Status
  logic        halted;
  logic        illegal;

  // Sequencer side
  modport master (
    output imem_req, pc, dmem_req, dmem_we,
    output DA, AA, BA, IM, CS, MB, FS, MD, RW, halted, illegal,
    input  imem_ack, imem_rdata, dmem_ack, zero, a_bus
  );

  // Memory / datapath side
  modport slave (
    input  imem_req, pc, dmem_req, dmem_we,
    input  DA, AA, BA, IM, CS, MB, FS, MD, RW, halted, illegal,
    output imem_ack, imem_rdata, dmem_ack, zero, a_bus
  );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multicycle fetch/decode/execute control sequencer for the
//               8-bit RISC core. Owns the PC and IR, drives the datapath
//               control word and sequences memory handshakes and branches.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] c_OP_NOP  = 4'h0;
  localparam logic [3:0] c_OP_ADD  = 4'h1;
  localparam logic [3:0] c_OP_SUB  = 4'h2;
  localparam logic [3:0] c_OP_AND  = 4'h3;
  localparam logic [3:0] c_OP_OR   = 4'h4;
  localparam logic [3:0] c_OP_ADDI = 4'h5;
  localparam logic [3:0] c_OP_ANDI = 4'h6;
  localparam logic [3:0] c_OP_LD   = 4'h7;
  localparam logic [3:0] c_OP_ST   = 4'h8;
  localparam logic [3:0] c_OP_BZ   = 4'h9;
  localparam logic [3:0] c_OP_JMP  = 4'hA;
  localparam logic [3:0] c_OP_HALT = 4'hF;

  localparam logic [2:0] c_FS_ADD  = 3'd0;
  localparam logic [2:0] c_FS_SUB  = 3'd1;
  localparam logic [2:0] c_FS_AND  = 3'd2;
  localparam logic [2:0] c_FS_OR   = 3'd3;
  localparam logic [2:0] c_FS_PASS = 3'd4;

  state_t      r_state;
  logic [15:0] r_ir;
  logic [7:0]  r_pc;
  logic        r_imem_req;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic        r_rw_exec;
  logic        r_halted;
  logic        r_illegal;

  logic [3:0]  w_op;
  logic        w_is_alu;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_is_bz;
  logic        w_is_jmp;
  logic        w_is_halt;
  logic        w_is_illegal;
  logic [7:0]  w_pc_inc;
  logic [7:0]  w_br_target;
  logic [2:0]  w_fs;

  assign w_op         = r_ir[15:12];
  assign w_is_alu     = (w_op >= c_OP_ADD) && (w_op <= c_OP_ANDI);
  assign w_is_ld      = (w_op == c_OP_LD);
  assign w_is_st      = (w_op == c_OP_ST);
  assign w_is_bz      = (w_op == c_OP_BZ);
  assign w_is_jmp     = (w_op == c_OP_JMP);
  assign w_is_halt    = (w_op == c_OP_HALT);
  assign w_is_illegal = (w_op > c_OP_JMP) && (w_op < c_OP_HALT);

  assign w_pc_inc     = r_pc + 8'd1;
  // Branch offset is relative to the already-incremented PC, wrapping mod 256
  assign w_br_target  = r_pc + {r_ir[5], r_ir[5], r_ir[5:0]};

  // Function select decode; memory and control-flow ops pass A through
  always_comb begin
    w_fs = c_FS_ADD;
    case (w_op)
      c_OP_ADD, c_OP_ADDI:              w_fs = c_FS_ADD;
      c_OP_SUB:                         w_fs = c_FS_SUB;
      c_OP_AND, c_OP_ANDI:              w_fs = c_FS_AND;
      c_OP_OR:                          w_fs = c_FS_OR;
      c_OP_LD, c_OP_ST, c_OP_BZ,
      c_OP_JMP:                         w_fs = c_FS_PASS;
      default:                          w_fs = c_FS_ADD;
    endcase
  end

  // Main sequencer: state, PC, IR and registered handshake/status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RST;
      r_ir       <= 16'h0000;
      r_pc       <= RESET_PC;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_rw_exec  <= 1'b0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        ST_RST: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            r_ir       <= bus.imem_rdata;
            r_pc       <= w_pc_inc;
            r_imem_req <= 1'b0;
            r_state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_state   <= ST_EXEC;
          r_rw_exec <= w_is_alu;
          if (w_is_illegal) begin
            r_illegal <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_rw_exec <= 1'b0;
          if (w_is_ld || w_is_st) begin
            r_state    <= ST_MEM;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= w_is_st;
          end else if (w_is_halt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            if (w_is_bz && bus.zero) begin
              r_pc <= w_br_target;
            end else if (w_is_jmp) begin
              r_pc <= bus.a_bus;
            end
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        ST_MEM: begin
          if (bus.dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_imem_req <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_RST;
        end
      endcase
    end
  end

  // Load write-back must coincide with the ack cycle, so that term is
  // qualified live by dmem_ack rather than registered
  assign bus.RW = r_rw_exec | ((r_state == ST_MEM) && w_is_ld && bus.dmem_ack);

  assign bus.imem_req = r_imem_req;
  assign bus.pc       = r_pc;
  assign bus.dmem_req = r_dmem_req;
  assign bus.dmem_we  = r_dmem_we;
  assign bus.halted   = r_halted;
  assign bus.illegal  = r_illegal;

  assign bus.DA = r_ir[11:9];
  assign bus.AA = r_ir[8:6];
  assign bus.BA = r_ir[2:0];
  assign bus.IM = r_ir[5:0];
  assign bus.CS = (w_op == c_OP_ADDI) || w_is_bz;
  assign bus.MB = (w_op == c_OP_ADDI) || (w_op == c_OP_ANDI);
  assign bus.FS = w_fs;
  assign bus.MD = w_is_ld;

endmodule
`default_nettype wire
